// File: rtl/ddr_wr_burst_ctrl_if.sv
// ddr_wr_burst_ctrl_if: FIFO read port and AXI4 write channel bundle for the
// DDR write burst controller. "master" is the controller side, "slave" is the
// FIFO / DDR controller side.
interface ddr_wr_burst_ctrl_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 28,
    parameter int LVL_WIDTH  = 11
);
    logic                    fifo_rd_en;
    logic [DATA_WIDTH-1:0]   fifo_rd_data;
    logic [LVL_WIDTH-1:0]    fifo_rd_water_level;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic                    bvalid;
    logic [1:0]              bresp;
    logic                    bready;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data, fifo_rd_water_level,
        output awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data, fifo_rd_water_level,
        input  awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/ddr_wr_burst_ctrl.sv
// ddr_wr_burst_ctrl: drains the 256-bit read side of the camera write FIFO into
// fixed-length AXI4 INCR write bursts on a linearly advancing, wrapping frame
// address. Optional macro DDR_WR_PINGPONG_EN alternates between two frame
// buffers on every applied frame_start.
//
// Handshakes: a transfer happens on the rising clk edge where valid and ready are
// both high; once valid is raised its payload stays stable until that transfer.
module ddr_wr_burst_ctrl #(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 28,
    parameter int BURST_LEN   = 16,
    parameter int LVL_WIDTH   = 11,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_BYTES = 3686400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    ddr_wr_burst_ctrl_if.master bus,
    output logic                frame_idx,
    output logic                busy,
    output logic                err,
    output logic [1:0]          state_dbg
);
    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int RCW         = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] FRAME_A = ADDR_WIDTH'(FRAME_BYTES);
    localparam logic [ADDR_WIDTH-1:0] STEP_A  = ADDR_WIDTH'(BURST_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_W    = 2'd2,
        S_B    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [ADDR_WIDTH-1:0] cur_base;
    logic [ADDR_WIDTH-1:0] restart_base;
    logic [ADDR_WIDTH-1:0] addr_sum;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  pending_q;
    logic                  err_q;
    logic                  restart;

    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            cnt_q;
    logic                  inflight_q;
    logic [2:0]            occ;
    logic [RCW-1:0]        req_cnt_q;
    logic [9:0]            beat_cnt_q;
    logic                  w_done_q;

    logic in_data_phase;
    logic rd_en;
    logic wvalid;
    logic wlast;
    logic w_hs;
    logic aw_hs;
    logic b_hs;

    // A restart is either a fresh pulse or one parked while a burst was running.
    assign restart = frame_start | pending_q;

`ifdef DDR_WR_PINGPONG_EN
    logic frame_idx_q;

    assign cur_base     = frame_idx_q ? (BASE_A + FRAME_A) : BASE_A;
    assign restart_base = frame_idx_q ? BASE_A : (BASE_A + FRAME_A);
    assign frame_idx    = frame_idx_q;

    // Each applied restart flips to the other frame buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_idx_q <= 1'b0;
        end else if (state_q == S_IDLE && restart) begin
            frame_idx_q <= ~frame_idx_q;
        end
    end
`else
    assign cur_base     = BASE_A;
    assign restart_base = BASE_A;
    assign frame_idx    = 1'b0;
`endif

    assign in_data_phase = (state_q == S_AW) || (state_q == S_W);
    assign wvalid        = (cnt_q != 2'd0);
    assign wlast         = wvalid && (beat_cnt_q == 10'(BURST_LEN - 1));
    assign w_hs          = wvalid && bus.wready;
    assign aw_hs         = (state_q == S_AW) && bus.awready;
    assign b_hs          = (state_q == S_B) && bus.bvalid;

    // Occupancy counts entries already held plus the read whose data is on the
    // bus now, net of the beat leaving this cycle; that credit keeps 1 beat/cycle.
    assign occ   = 3'(cnt_q) + 3'(inflight_q) - 3'(w_hs);
    assign rd_en = in_data_phase && (occ < 3'd2) && (req_cnt_q < RCW'(BURST_LEN));

    assign addr_sum  = awaddr_q + STEP_A;
    assign addr_next = (addr_sum == cur_base + FRAME_A) ? cur_base : addr_sum;

    assign bus.fifo_rd_en = rd_en;
    assign bus.awaddr     = awaddr_q;
    assign bus.awlen      = 8'(BURST_LEN - 1);
    assign bus.awvalid    = (state_q == S_AW);
    assign bus.wdata      = buf_mem[rd_ptr_q];
    assign bus.wstrb      = '1;
    assign bus.wlast      = wlast;
    assign bus.wvalid     = wvalid;
    assign bus.bready     = (state_q == S_B);

    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign state_dbg = state_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a restart in IDLE is applied first and delays the burst a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!restart && (bus.fifo_rd_water_level >= LVL_WIDTH'(BURST_LEN))) begin
                    state_d = S_AW;
                end
            end
            S_AW: begin
                if (aw_hs) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                // w_done_q covers a burst whose data all drained before awready.
                if ((w_hs && wlast) || w_done_q) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bus.bvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Two-entry prefetch buffer fed one cycle after each FIFO read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            if (inflight_q) begin
                buf_mem[wr_ptr_q] <= bus.fifo_rd_data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (w_hs) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= 2'(3'(cnt_q) + 3'(inflight_q) - 3'(w_hs));
        end
    end

    // Per-burst read request and beat counters, cleared while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
            w_done_q   <= 1'b0;
        end else if (state_q == S_IDLE) begin
            req_cnt_q  <= '0;
            beat_cnt_q <= '0;
            w_done_q   <= 1'b0;
        end else begin
            if (rd_en) begin
                req_cnt_q <= req_cnt_q + RCW'(1);
            end
            if (w_hs) begin
                beat_cnt_q <= beat_cnt_q + 10'd1;
                if (wlast) begin
                    w_done_q <= 1'b1;
                end
            end
        end
    end

    // Burst address: advance on each response, reload the frame base on restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awaddr_q  <= BASE_A;
            pending_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (restart) begin
                awaddr_q  <= restart_base;
                pending_q <= 1'b0;
            end
        end else begin
            if (frame_start) begin
                pending_q <= 1'b1;
            end
            if (b_hs) begin
                awaddr_q <= addr_next;
            end
        end
    end

    // Any non-OKAY response latches the error until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (b_hs && (bus.bresp != 2'b00)) begin
            err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// tb_ddr_wr_burst_ctrl: directed sequence with randomized data and handshake
// timing, checked against a burst-level address/data model.
module tb_ddr_wr_burst_ctrl;
    localparam int DW    = 256;
    localparam int AW    = 28;
    localparam int LW    = 11;
    localparam int BL    = 16;
    localparam int BASE  = 0;
    localparam int FRAME = 8192;
    localparam int BB    = BL * DW / 8;
`ifdef DDR_WR_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       tb_rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_idx;
    logic       busy;
    logic       err;
    logic [1:0] state_dbg;

    ddr_wr_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LVL_WIDTH(LW)) bus ();

    ddr_wr_burst_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .LVL_WIDTH(LW),
        .BASE_ADDR(BASE), .FRAME_BYTES(FRAME)
    ) dut (
        .clk(clk), .rst(tb_rst), .frame_start(frame_start), .bus(bus),
        .frame_idx(frame_idx), .busy(busy), .err(err), .state_dbg(state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // FIFO model and scoreboard
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] aw_q[$];
    bit            rd_pend = 1'b0;

    // handshake responder modes
    int       wr_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 stalled
    bit       aw_rand = 1'b0;
    bit       b_rand  = 1'b0;
    logic [1:0] bresp_val = 2'b00;

    // reference model state
    logic [AW-1:0] exp_addr = AW'(BASE);
    bit            exp_idx  = 1'b0;
    int            exp_bursts = 0;
    int            rd_mark = 0;

    // monitor state
    int  cyc = 0, b_cnt = 0, rd_cnt = 0, beat_idx = 0, first_cyc = 0, last_span = -1;
    bit  stall_prev = 1'b0;
    logic [DW-1:0] stall_data = '0;

    function automatic logic [AW-1:0] base_of(input bit idx);
        return AW'(BASE) + ((PP && idx) ? AW'(FRAME) : AW'(0));
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // FIFO read side: data for a read appears after the edge that took it.
    always @(negedge clk) begin
        if (tb_rst) begin
            rd_pend = 1'b0;
        end else if (rd_pend) begin
            if (fifo_q.size() != 0) bus.fifo_rd_data = fifo_q.pop_front();
            rd_pend = 1'b0;
            bus.fifo_rd_water_level = LW'(fifo_q.size());
        end
    end

    // AXI slave responder
    always @(negedge clk) begin
        case (wr_mode)
            0: bus.wready = 1'b1;
            1: bus.wready = ~bus.wready;
            2: bus.wready = 1'($urandom_range(0, 1));
            default: bus.wready = 1'b0;
        endcase
        bus.awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.bvalid  = bus.bready && (b_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        bus.bresp   = bresp_val;
    end

    // monitor: samples just before each rising edge
    always @(negedge clk) begin
        #4;
        cyc++;
        if (tb_rst) begin
            beat_idx   = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("w_hold_valid", bus.wvalid, 1);
                check("w_hold_data", bus.wdata, stall_data);
            end
            stall_prev = bus.wvalid && !bus.wready;
            stall_data = bus.wdata;
            if (bus.awvalid && bus.awready) begin
                aw_q.push_back(bus.awaddr);
                check("awlen", bus.awlen, BL - 1);
            end
            if (bus.wvalid && bus.wready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("wdata", bus.wdata, exp_q.pop_front());
                check("wlast", bus.wlast, beat_idx == BL - 1);
                if (beat_idx == 0) first_cyc = cyc;
                if (beat_idx == BL - 1) begin
                    last_span = cyc - first_cyc;
                    beat_idx  = 0;
                end else begin
                    beat_idx++;
                end
            end
            if (bus.bvalid && bus.bready) b_cnt++;
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                check("rd_nonempty", fifo_q.size() != 0, 1);
                rd_pend = 1'b1;
            end
        end
    end

    // driver tasks (called right after a falling edge)
    task automatic push(input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rand_beat();
            fifo_q.push_back(d);
            exp_q.push_back(d);
        end
        bus.fifo_rd_water_level = LW'(fifo_q.size());
    endtask

    task automatic start_burst();
        exp_bursts = b_cnt + 1;
        rd_mark    = rd_cnt;
        push(BL);
    endtask

    task automatic finish_burst(input bit restart);
        int budget = 0;
        int off;
        while (b_cnt < exp_bursts && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        check("burst_done", b_cnt >= exp_bursts, 1);
        check("rd_count", rd_cnt - rd_mark, BL);
        check("aw_seen", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) check("awaddr_burst", aw_q.pop_front(), exp_addr);
        if (restart) begin
            if (PP) exp_idx = ~exp_idx;
            exp_addr = base_of(exp_idx);
        end else begin
            off      = int'(exp_addr) - int'(base_of(exp_idx));
            off      = (off + BB) % FRAME;
            exp_addr = base_of(exp_idx) + AW'(off);
        end
        repeat (3) @(negedge clk);
        check("awaddr_next", bus.awaddr, exp_addr);
        check("idle_after", busy, 0);
        check("frame_idx", frame_idx, exp_idx);
    endtask

    task automatic run_burst();
        start_burst();
        finish_burst(1'b0);
    endtask

    // watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.fifo_rd_data = '0;
        bus.fifo_rd_water_level = '0;
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.bvalid = 1'b0;
        bus.bresp = 2'b00;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_awaddr", bus.awaddr, BASE);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_wlast", bus.wlast, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_frame_idx", frame_idx, 0);
        check("rst_wdata", bus.wdata, 0);
        check("awlen_const", bus.awlen, BL - 1);
        check("wstrb_ones", bus.wstrb, {(DW/8){1'b1}});
        tb_rst = 1'b0;
        @(negedge clk);

        // one burst with everything ready
        run_burst();
        check("beats_back_to_back", last_span, BL - 1);
        check("err_clean", err, 0);

        // wready toggling
        wr_mode = 1;
        run_burst();
        wr_mode = 0;
        check("scoreboard_drained", exp_q.size(), 0);

        // level one short of a burst
        exp_bursts = b_cnt + 1;
        rd_mark = rd_cnt;
        push(BL - 1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.awvalid || busy) seen = 1'b1;
        end
        check("no_burst_below_level", seen, 0);
        push(1);
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus.awvalid) seen = 1'b1;
        end
        check("aw_within_2", seen, 1);
        finish_burst(1'b0);

        // randomized handshake timing
        aw_rand = 1'b1; b_rand = 1'b1; wr_mode = 2;
        for (int i = 0; i < 10; i++) run_burst();
        aw_rand = 1'b0; b_rand = 1'b0; wr_mode = 0;

        // run up to the frame end and across the wrap
        while (exp_addr != base_of(exp_idx) + AW'(FRAME - BB)) run_burst();
        run_burst();
        check("wrap_to_base", bus.awaddr, base_of(exp_idx));

        // restart during W at 0x1000
        while (exp_addr != base_of(exp_idx) + AW'(32'h1000)) run_burst();
        wr_mode = 3;
        start_burst();
        repeat (6) @(negedge clk);
        check("busy_before_restart", busy, 1);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wr_mode = 0;
        finish_burst(1'b1);

        // restart while idle
        run_burst();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (PP) exp_idx = ~exp_idx;
        exp_addr = base_of(exp_idx);
        check("idle_restart_addr", bus.awaddr, exp_addr);
        check("idle_restart_idx", frame_idx, exp_idx);

        // restart in the same cycle the level qualifies
        run_burst();
        frame_start = 1'b1;
        start_burst();
        @(negedge clk);
        frame_start = 1'b0;
        if (PP) exp_idx = ~exp_idx;
        exp_addr = base_of(exp_idx);
        check("aw_delayed_by_restart", bus.awvalid, 0);
        check("restart_addr_before_aw", bus.awaddr, exp_addr);
        @(negedge clk);
        check("aw_after_restart", bus.awvalid, 1);
        finish_burst(1'b0);

        // error response is sticky
        bresp_val = 2'b10;
        run_burst();
        check("err_set", err, 1);
        bresp_val = 2'b00;
        run_burst();
        check("err_sticky_1", err, 1);
        run_burst();
        check("err_sticky_2", err, 1);

        // reset mid-burst
        wr_mode = 3;
        start_burst();
        repeat (6) @(negedge clk);
        check("wvalid_before_rst", bus.wvalid, 1);
        #1 tb_rst = 1'b1;
        #1;
        check("arst_awvalid", bus.awvalid, 0);
        check("arst_wvalid", bus.wvalid, 0);
        check("arst_rd_en", bus.fifo_rd_en, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err, 0);
        check("arst_awaddr", bus.awaddr, BASE);
        check("arst_frame_idx", frame_idx, 0);
        fifo_q.delete();
        exp_q.delete();
        aw_q.delete();
        bus.fifo_rd_water_level = '0;
        exp_idx = 1'b0;
        exp_addr = AW'(BASE);
        @(negedge clk);
        wr_mode = 0;
        @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);
        run_burst();
        check("err_after_rst", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
